dice_result_display: RTL and testbench
======================================

// Module: dice_result_display
// PURPOSE
//  Consumer end of the dice-roll path: samples the free-running 8-bit roll value
//  on a debounced throw press and freezes it. Converts it to BCD with a
//  sequential double-dabble and drives three 7-segment digits with
//  leading-zero blanking. Sits between throw_dice.new_value and the board displays.
// PARAMETERS
//  WIDTH          8  width of new_value/result; conversion runs WIDTH iterations
//  SEG_ACTIVE_LOW 1  1: segment on = 0 (board default); 0: segment on = 1
// PORTS
//  Clk           in   1      single system clock
//  rst_n         in   1      reset, asynchronous, active-low
//  throw         in   1      raw throw button level (asynchronous to Clk)
//  new_value     in   WIDTH  current roll value from the dice generator
//  dice          in   3      dice type code (D4=0 .. D100=7)
//  busy          out  1      capture/conversion in progress; throws ignored
//  result_valid  out  1      BCD and segment outputs reflect the last capture
//  result        out  WIDTH  frozen roll value
//  result_dice   out  3      dice type frozen with result
//  bcd_h/t/u     out  4 each hundreds/tens/units BCD digits
//  seg_h/t/u     out  7 each segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; busy=0, result_valid=0, result=0,
//   result_dice=0, bcd_*=0, all seg_* blank (all segments off).
//   Synchronizer flops are cleared.
//  Input path: throw -> 2-flop synchronizer -> edge register.
//   throw_pulse = sync2 & ~sync3, lasting one cycle per rising edge.
//   A held button gives exactly one pulse.
//  FSM states: IDLE, CONVERT, DONE.
//   IDLE/DONE + throw_pulse: load result<=new_value, result_dice<=dice, and the
//    shift register {bcd=0, bin=new_value}. Set iter=0, busy=1, result_valid=0 -> CONVERT.
//   CONVERT: each cycle, add 3 to every BCD nibble >=5, then shift left 1.
//    iter increments each cycle. On iter==WIDTH-1, the last shift is done, bcd_h/t/u
//    are registered from the shift result, busy=0, result_valid=1 -> DONE.
//   throw_pulse while CONVERT: ignored, no queuing.
//  Latency: if throw is first sampled high at edge k, capture happens at edge k+2.
//   result_valid rises at edge k+2+WIDTH (k+10 for WIDTH=8).
//  bcd_* and seg_* hold previous values during CONVERT. They update atomically at
//   the DONE entry edge. result_valid stays 1 until the next capture.
//  Arithmetic: 0..255 maps to 3 digits. The BCD nibble width is 4, so add-3 never
//   overflows. Values 0 (D10/D100 roll) show units "0" only.
//  Blanking: seg_h is blank if bcd_h==0. seg_t is blank if bcd_h==0 && bcd_t==0.
//   seg_u is never blank after the first DONE. Before the first DONE, all are blank.
//  Segment outputs are combinational from registered bcd_* and the blank flags.
//   They are glitch-free between updates.
//  Reset mid-CONVERT: aborts immediately and returns to full reset values.
//  The DONE-entry edge and throw_pulse in the same cycle: the pulse is ignored.
//   Only a pulse seen in DONE starts a new capture.
// STRUCTURE
//  Shared include dice_defs.vh:
//   - dice code localparams D4..D100, shared with throw_dice
//   - FSM state encodings
//   - 7-seg digit patterns 0-9 and SEG_BLANK
//  Sub-module seg7_decoder (combinational: bcd[3:0], blank, polarity param ->
//   seg[6:0]), instantiated 3 times.
//  Double-dabble stays inline in this module: iteration counter plus shift register.
// TESTING
//  1 Reset: rst_n=0 for 3 cycles, mid-run too -> all outputs at reset values,
//    seg_* = 7'h7F, busy=0.
//  2 new_value=100, dice=D100, single throw press -> result_valid at k+10.
//    bcd=1,0,0; seg_h="1", seg_t="0", seg_u="0".
//  3 new_value=7 -> bcd=0,0,7; seg_h and seg_t blank, seg_u=7'b1111000 (active-low "7").
//    new_value=0 -> seg_u="0".
//  4 new_value=255 (WIDTH=8 corner) -> bcd=2,5,5.
//    Change new_value after capture -> result remains 255.
//  5 Second throw edge at k+5 during CONVERT -> ignored; one conversion only.
//    Button held 50 cycles -> exactly one capture.
//  6 Assert rst_n=0 at k+6 mid-CONVERT -> immediate reset values.
//    A throw after release converts normally.

Source files
------------

// File: rtl/dice_result_display_pkg.sv
// Shared definitions for the dice result display path.
// Dice codes, FSM states, 7-segment patterns and BCD helpers.
package dice_result_display_pkg;

  localparam logic [2:0] D4   = 3'd0;
  localparam logic [2:0] D6   = 3'd1;
  localparam logic [2:0] D8   = 3'd2;
  localparam logic [2:0] D10  = 3'd3;
  localparam logic [2:0] D12  = 3'd4;
  localparam logic [2:0] D20  = 3'd5;
  localparam logic [2:0] D00  = 3'd6;
  localparam logic [2:0] D100 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam int BCD_DIGITS = 3;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Non-decimal codes show nothing rather than garbage
  function automatic logic [6:0] seg_pattern(
    input logic [3:0] d
  );
    logic [6:0] p;
    case (d)
      4'd0:    p = SEG_0;
      4'd1:    p = SEG_1;
      4'd2:    p = SEG_2;
      4'd3:    p = SEG_3;
      4'd4:    p = SEG_4;
      4'd5:    p = SEG_5;
      4'd6:    p = SEG_6;
      4'd7:    p = SEG_7;
      4'd8:    p = SEG_8;
      4'd9:    p = SEG_9;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

  // Double-dabble correction: +3 on every nibble >= 5
  function automatic logic [BCD_W-1:0] dd_adjust(
    input logic [BCD_W-1:0] b
  );
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/dice_result_display_seg7_decoder.sv
// One 7-segment digit: BCD code plus blank flag to segments.
// Purely combinational; polarity chosen by parameter.
module seg7_decoder
  import dice_result_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  logic [6:0] w_on;

  // Select lit segments, then apply board polarity
  always_comb begin
    w_on = i_blank ? SEG_BLANK : seg_pattern(i_bcd);
    o_seg = SEG_ACTIVE_LOW ? ~w_on : w_on;
  end

endmodule

// File: rtl/dice_result_display.sv
// Captures a dice roll on a throw press, converts it to BCD
// with a sequential double-dabble and drives three digits.
module dice_result_display
  import dice_result_display_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             Clk,
  input  logic             rst_n,
  input  logic             throw,
  input  logic [WIDTH-1:0] new_value,
  input  logic [2:0]       dice,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       result_dice,
  output logic [3:0]       bcd_h,
  output logic [3:0]       bcd_t,
  output logic [3:0]       bcd_u,
  output logic [6:0]       seg_h,
  output logic [6:0]       seg_t,
  output logic [6:0]       seg_u
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = BCD_W + WIDTH;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_sync3;
  logic          w_throw_pulse;

  state_t        r_state;
  state_t        w_next;

  logic [SW-1:0] r_sr;
  logic [SW-1:0] w_adj;
  logic [SW-1:0] w_shift;
  logic [IW-1:0] r_iter;
  logic          w_last;
  logic          w_capture;

  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_dice;
  logic [3:0]       r_bcd_h;
  logic [3:0]       r_bcd_t;
  logic [3:0]       r_bcd_u;
  logic             r_shown;

  logic w_blank_h;
  logic w_blank_t;
  logic w_blank_u;

  // Two-flop synchronizer plus edge register for the button
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= throw;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_throw_pulse = r_sync2 & ~r_sync3;

  // Only IDLE/DONE accept a press; CONVERT drops it
  assign w_capture = w_throw_pulse &
    ((r_state == ST_IDLE) | (r_state == ST_DONE));

  assign w_last = (r_iter == IW'(WIDTH - 1));

  // One double-dabble step: correct nibbles, shift left
  always_comb begin
    w_adj   = {dd_adjust(r_sr[SW-1 -: BCD_W]), r_sr[WIDTH-1:0]};
    w_shift = {w_adj[SW-2:0], 1'b0};
  end

  // FSM state register
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_capture) w_next = ST_CONVERT;
      ST_CONVERT: if (w_last)    w_next = ST_DONE;
      ST_DONE:    if (w_capture) w_next = ST_CONVERT;
      default:    w_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy         = (r_state == ST_CONVERT);
    result_valid = (r_state == ST_DONE);
  end

  // Capture, conversion datapath and atomic digit update
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr     <= '0;
      r_iter   <= '0;
      r_result <= '0;
      r_dice   <= '0;
      r_bcd_h  <= '0;
      r_bcd_t  <= '0;
      r_bcd_u  <= '0;
      r_shown  <= 1'b0;
    end else if (w_capture) begin
      r_result <= new_value;
      r_dice   <= dice;
      r_sr     <= {{BCD_W{1'b0}}, new_value};
      r_iter   <= '0;
    end else if (r_state == ST_CONVERT) begin
      r_sr   <= w_shift;
      r_iter <= r_iter + IW'(1);
      if (w_last) begin
        r_bcd_h <= w_shift[WIDTH+8 +: 4];
        r_bcd_t <= w_shift[WIDTH+4 +: 4];
        r_bcd_u <= w_shift[WIDTH   +: 4];
        r_shown <= 1'b1;
      end
    end
  end

  assign result      = r_result;
  assign result_dice = r_dice;
  assign bcd_h       = r_bcd_h;
  assign bcd_t       = r_bcd_t;
  assign bcd_u       = r_bcd_u;

  // Leading-zero blanking; everything dark until first result
  always_comb begin
    w_blank_h = ~r_shown | (r_bcd_h == 4'd0);
    w_blank_t = ~r_shown |
      ((r_bcd_h == 4'd0) & (r_bcd_t == 4'd0));
    w_blank_u = ~r_shown;
  end

  seg7_decoder #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_seg_h (
    .i_bcd  (r_bcd_h),
    .i_blank(w_blank_h),
    .o_seg  (seg_h)
  );

  seg7_decoder #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_seg_t (
    .i_bcd  (r_bcd_t),
    .i_blank(w_blank_t),
    .o_seg  (seg_t)
  );

  seg7_decoder #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_seg_u (
    .i_bcd  (r_bcd_u),
    .i_blank(w_blank_u),
    .o_seg  (seg_u)
  );

endmodule

// File: tb/tb_dice_result_display.sv
// Directed bench for dice_result_display.
// Vector table plus hand sequences for the multi-cycle cases.
module tb_dice_result_display;

  logic       Clk;
  logic       rst_n;
  logic       throw;
  logic [7:0] new_value;
  logic [2:0] dice;
  logic       busy;
  logic       result_valid;
  logic [7:0] result;
  logic [2:0] result_dice;
  logic [3:0] bcd_h, bcd_t, bcd_u;
  logic [6:0] seg_h, seg_t, seg_u;

  int total = 0;
  int bad   = 0;

  // Active-low digit patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] L0 = 7'h40;
  localparam logic [6:0] L1 = 7'h79;
  localparam logic [6:0] L2 = 7'h24;
  localparam logic [6:0] L4 = 7'h19;
  localparam logic [6:0] L5 = 7'h12;
  localparam logic [6:0] L7 = 7'h78;
  localparam logic [6:0] L9 = 7'h10;
  localparam logic [6:0] BL = 7'h7F;

  dice_result_display #(
    .WIDTH(8),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .Clk         (Clk),
    .rst_n       (rst_n),
    .throw       (throw),
    .new_value   (new_value),
    .dice        (dice),
    .busy        (busy),
    .result_valid(result_valid),
    .result      (result),
    .result_dice (result_dice),
    .bcd_h       (bcd_h),
    .bcd_t       (bcd_t),
    .bcd_u       (bcd_u),
    .seg_h       (seg_h),
    .seg_t       (seg_t),
    .seg_u       (seg_u)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".valid"}, int'(result_valid), 0);
    chk({tag, ".result"}, int'(result), 0);
    chk({tag, ".rdice"}, int'(result_dice), 0);
    chk({tag, ".bcd"}, int'({bcd_h, bcd_t, bcd_u}), 0);
    chk({tag, ".seg_h"}, int'(seg_h), int'(BL));
    chk({tag, ".seg_t"}, int'(seg_t), int'(BL));
    chk({tag, ".seg_u"}, int'(seg_u), int'(BL));
  endtask

  // Press throw (first sampled at edge n=0), hold for `hold` edges,
  // optionally re-press so it is sampled at edge `again`.
  task automatic run_throw(
    input  logic [7:0] nv,
    input  logic [2:0] d,
    input  int         hold,
    input  int         again,
    input  int         cycles,
    output int         lat,
    output int         rises,
    output logic [6:0] mid_seg_u
  );
    logic pb;
    pb = busy;
    lat = -1;
    rises = 0;
    mid_seg_u = 7'h00;
    @(negedge Clk);
    new_value = nv;
    dice = d;
    throw = 1'b1;
    for (int n = 0; n < cycles; n++) begin
      @(posedge Clk);
      #1;
      if (n == hold - 1) throw = 1'b0;
      if (n == again - 1) throw = 1'b1;
      if (n == again) throw = 1'b0;
      if (busy && !pb) rises++;
      if (result_valid && rises > 0 && lat < 0) lat = n;
      if (n == 5) mid_seg_u = seg_u;
      pb = busy;
    end
    throw = 1'b0;
  endtask

  typedef struct {
    logic [7:0] nv;
    logic [2:0] d;
    logic [3:0] h, t, u;
    logic [6:0] sh, st, su;
  } vec_t;

  vec_t vt[9];

  initial begin
    int lat, rises;
    logic [6:0] mid;
    logic [6:0] prev_su;

    vt[0] = '{8'd100, 3'd7, 4'd1, 4'd0, 4'd0, L1, L0, L0};
    vt[1] = '{8'd7,   3'd1, 4'd0, 4'd0, 4'd7, BL, BL, L7};
    vt[2] = '{8'd0,   3'd3, 4'd0, 4'd0, 4'd0, BL, BL, L0};
    vt[3] = '{8'd42,  3'd5, 4'd0, 4'd4, 4'd2, BL, L4, L2};
    vt[4] = '{8'd10,  3'd3, 4'd0, 4'd1, 4'd0, BL, L1, L0};
    vt[5] = '{8'd199, 3'd7, 4'd1, 4'd9, 4'd9, L1, L9, L9};
    vt[6] = '{8'd250, 3'd6, 4'd2, 4'd5, 4'd0, L2, L5, L0};
    vt[7] = '{8'd5,   3'd0, 4'd0, 4'd0, 4'd5, BL, BL, L5};
    vt[8] = '{8'd255, 3'd2, 4'd2, 4'd5, 4'd5, L2, L5, L5};

    rst_n = 1'b0;
    throw = 1'b0;
    new_value = 8'd0;
    dice = 3'd0;
    repeat (3) @(negedge Clk);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge Clk);
    chk_reset("idle");

    prev_su = BL;
    for (int i = 0; i < 9; i++) begin
      run_throw(vt[i].nv, vt[i].d, 1, -1, 14, lat, rises, mid);
      chk($sformatf("v%0d.latency", i), lat, 10);
      chk($sformatf("v%0d.captures", i), rises, 1);
      chk($sformatf("v%0d.seg_u_hold", i), int'(mid), int'(prev_su));
      chk($sformatf("v%0d.valid", i), int'(result_valid), 1);
      chk($sformatf("v%0d.result", i), int'(result), int'(vt[i].nv));
      chk($sformatf("v%0d.rdice", i), int'(result_dice), int'(vt[i].d));
      chk($sformatf("v%0d.bcd_h", i), int'(bcd_h), int'(vt[i].h));
      chk($sformatf("v%0d.bcd_t", i), int'(bcd_t), int'(vt[i].t));
      chk($sformatf("v%0d.bcd_u", i), int'(bcd_u), int'(vt[i].u));
      chk($sformatf("v%0d.seg_h", i), int'(seg_h), int'(vt[i].sh));
      chk($sformatf("v%0d.seg_t", i), int'(seg_t), int'(vt[i].st));
      chk($sformatf("v%0d.seg_u", i), int'(seg_u), int'(vt[i].su));
      prev_su = vt[i].su;
    end

    // Roll keeps changing after capture; result stays frozen
    new_value = 8'd13;
    repeat (4) @(negedge Clk);
    chk("frozen.result", int'(result), 255);
    chk("frozen.bcd", int'({bcd_h, bcd_t, bcd_u}), 12'h255);

    // Second edge sampled at k+5 lands in CONVERT and is dropped
    run_throw(8'd42, 3'd5, 2, 5, 30, lat, rises, mid);
    chk("repress.captures", rises, 1);
    chk("repress.latency", lat, 10);
    chk("repress.bcd", int'({bcd_h, bcd_t, bcd_u}), 12'h042);

    // Button held 50 cycles gives one capture
    run_throw(8'd199, 3'd7, 50, -1, 60, lat, rises, mid);
    chk("held.captures", rises, 1);
    chk("held.latency", lat, 10);
    chk("held.result", int'(result), 199);

    // Reset at k+6 mid-CONVERT aborts at once
    @(negedge Clk);
    new_value = 8'd77;
    dice = 3'd4;
    throw = 1'b1;
    for (int n = 0; n <= 6; n++) begin
      @(posedge Clk);
      #1;
      if (n == 0) throw = 1'b0;
      if (n == 6) chk("midrst.busy_before", int'(busy), 1);
    end
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    repeat (3) @(negedge Clk);
    chk_reset("midrst.hold");
    rst_n = 1'b1;
    run_throw(8'd7, 3'd1, 1, -1, 14, lat, rises, mid);
    chk("post.latency", lat, 10);
    chk("post.seg_mid_blank", int'(mid), int'(BL));
    chk("post.bcd", int'({bcd_h, bcd_t, bcd_u}), 12'h007);
    chk("post.seg_h", int'(seg_h), int'(BL));
    chk("post.seg_t", int'(seg_t), int'(BL));
    chk("post.seg_u", int'(seg_u), int'(L7));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
